// File: rtl/pipelined_alu.sv
// pipelined_alu: pipelined multi-op ALU (ops 0-15), STAGES latency, en stall, async reset; MUL gated by PIPELINED_ALU_MULT_EN; ports clk reset en valid_in op left right -> out flag err valid_out busy
module pipelined_alu #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             valid_in,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             flag,
  output logic             err,
  output logic             valid_out,
  output logic             busy
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_flag, res_err, cmp;
  logic [STAGES-1:0] v, f, e;
  logic [WIDTH-1:0] d [STAGES];
`ifdef PIPELINED_ALU_MULT_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, left} * {{WIDTH{1'b0}}, right};
`endif
  always_comb begin
    sum = {1'b0, left} + {1'b0, right};
    res = '0;
    res_flag = 1'b0;
    res_err = 1'b0;
    cmp = op == 4'd9  ? left == right :
          op == 4'd10 ? left <  right :
          op == 4'd11 ? left >  right :
          op == 4'd12 ? left <= right :
                        left >= right;
    case (op)
      4'd0: {res_flag, res} = sum;
      4'd1: begin
        res = left - right;
        res_flag = left < right;
      end
      4'd2: res = left & right;
      4'd3: res = left | right;
      4'd4: res = left ^ right;
      4'd5: res = ~left;
      4'd6: res = left << right;
      4'd7: res = left >> right;
      4'd8: res = $signed(left) >>> right;
      4'd9, 4'd10, 4'd11, 4'd12, 4'd13: begin
        res = WIDTH'(cmp);
        res_flag = cmp;
      end
`ifdef PIPELINED_ALU_MULT_EN
      4'd14: begin
        res = prod[WIDTH-1:0];
        res_flag = |prod[2*WIDTH-1:WIDTH];
      end
`else
      4'd14: res_err = 1'b1;
`endif
      default: res = left;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      v <= '0;
      f <= '0;
      e <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else if (en) begin
      v[0] <= valid_in;
      d[0] <= res;
      f[0] <= res_flag;
      e[0] <= res_err;
      for (int i = 1; i < STAGES; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
        f[i] <= f[i-1];
        e[i] <= e[i-1];
      end
    end
  assign out = d[STAGES-1];
  assign flag = f[STAGES-1];
  assign err = e[STAGES-1];
  assign valid_out = v[STAGES-1];
  assign busy = |v;
endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: directed self-checking bench for pipelined_alu at WIDTH=8, STAGES=3
module tb_pipelined_alu;
  logic clk, reset, en, valid_in;
  logic [3:0] op;
  logic [7:0] left, right, out;
  logic flag, err, valid_out, busy;
  int checks = 0;
  int failures = 0;
  pipelined_alu #(.WIDTH(8), .STAGES(3)) dut (
    .clk(clk), .reset(reset), .en(en), .valid_in(valid_in), .op(op),
    .left(left), .right(right), .out(out), .flag(flag), .err(err),
    .valid_out(valid_out), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] o, input logic [7:0] l, input logic [7:0] r);
    op = o;
    left = l;
    right = r;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask
  task automatic run(input string tag, input logic [3:0] o, input logic [7:0] l, input logic [7:0] r,
                     input logic [7:0] eo, input logic ef, input logic ee);
    issue(o, l, r);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " valid"}, valid_out, 1);
    chk({tag, " out"}, out, eo);
    chk({tag, " flag"}, flag, ef);
    chk({tag, " err"}, err, ee);
  endtask
  logic       s_en [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  logic       s_vi [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  logic [7:0] s_l  [10] = '{1, 2, 3, 99, 99, 4, 5, 0, 0, 0};
  logic       s_ev [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [7:0] s_eo [10] = '{0, 0, 2, 2, 2, 4, 6, 8, 10, 0};
  logic       s_eb [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [7:0] c_eo [5] = '{1, 0, 0, 1, 1};
  initial begin
    reset = 1'b1;
    en = 1'b0;
    valid_in = 1'b0;
    op = 4'd0;
    left = 8'd0;
    right = 8'd0;
    #1;
    chk("rst out", out, 0);
    chk("rst flag", flag, 0);
    chk("rst err", err, 0);
    chk("rst valid", valid_out, 0);
    chk("rst busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    en = 1'b1;
    issue(4'd0, 8'd200, 8'd100);
    chk("add busy e1", busy, 1);
    chk("add valid e1", valid_out, 0);
    @(posedge clk);
    #1;
    chk("add valid e2", valid_out, 0);
    @(posedge clk);
    #1;
    chk("add valid e3", valid_out, 1);
    chk("add out", out, 44);
    chk("add flag", flag, 1);
    chk("add err", err, 0);
    @(posedge clk);
    #1;
    chk("add valid e4", valid_out, 0);
    chk("add busy e4", busy, 0);
    run("add nc", 4'd0, 8'd3, 8'd4, 8'd7, 0, 0);
    run("sub", 4'd1, 8'd5, 8'd7, 8'd254, 1, 0);
    run("sub nb", 4'd1, 8'd9, 8'd7, 8'd2, 0, 0);
    run("and", 4'd2, 8'hF0, 8'h3C, 8'h30, 0, 0);
    run("or", 4'd3, 8'hF0, 8'h0C, 8'hFC, 0, 0);
    run("xor", 4'd4, 8'hFF, 8'h0F, 8'hF0, 0, 0);
    run("not", 4'd5, 8'h5A, 8'h00, 8'hA5, 0, 0);
    run("shl3", 4'd6, 8'h90, 8'd3, 8'h80, 0, 0);
    run("shr1", 4'd7, 8'h90, 8'd1, 8'h48, 0, 0);
    run("sra2", 4'd8, 8'h90, 8'd2, 8'hE4, 0, 0);
    run("sra9", 4'd8, 8'h90, 8'd9, 8'hFF, 0, 0);
    run("shr8", 4'd7, 8'h90, 8'd8, 8'h00, 0, 0);
    run("shl200", 4'd6, 8'h90, 8'd200, 8'h00, 0, 0);
    run("pass", 4'd15, 8'h77, 8'h11, 8'h77, 0, 0);
    for (int i = 0; i < 5; i++)
      run($sformatf("cmp op%0d", 9 + i), 4'(9 + i), 8'd7, 8'd7, c_eo[i], c_eo[i][0], 0);
    run("lt 3<7", 4'd10, 8'd3, 8'd7, 8'd1, 1, 0);
    run("gt 3>7", 4'd11, 8'd3, 8'd7, 8'd0, 0, 0);
`ifdef PIPELINED_ALU_MULT_EN
    run("mul", 4'd14, 8'd16, 8'd17, 8'h10, 1, 0);
`else
    run("mul", 4'd14, 8'd16, 8'd17, 8'h00, 0, 1);
`endif
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      en = s_en[c];
      valid_in = s_vi[c];
      op = 4'd0;
      left = s_l[c];
      right = s_l[c];
      @(posedge clk);
      #1;
      chk($sformatf("stream valid c%0d", c + 1), valid_out, s_ev[c]);
      chk($sformatf("stream busy c%0d", c + 1), busy, s_eb[c]);
      if (s_ev[c]) chk($sformatf("stream out c%0d", c + 1), out, s_eo[c]);
    end
    en = 1'b1;
    valid_in = 1'b0;
    for (int i = 1; i <= 3; i++) issue(4'd0, 8'(i), 8'(i));
    chk("flight valid", valid_out, 1);
    chk("flight out", out, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst valid", valid_out, 0);
    chk("arst out", out, 0);
    chk("arst busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post rst valid c%0d", c), valid_out, 0);
      chk($sformatf("post rst busy c%0d", c), busy, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
